// File: rtl/sm_pkg.sv
// Shared types and width helpers for the sequential stable-matching engine.
package sm_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } sm_state_e;

    // ceil(log2(x)) with a floor of one bit so single-member lists still get an index.
    function automatic int unsigned sm_log2(input int unsigned x);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(x)) w++;
        return w;
    endfunction

    // Width of a counter that must hold 0..max_val inclusive.
    function automatic int unsigned sm_cnt_w(input int unsigned max_val);
        return sm_log2(max_val + 1);
    endfunction

endpackage

// File: rtl/stable_matching_seq_if.sv
// Start/done handshake, preference inputs and match results of the matching engine.
interface stable_matching_seq_if
    import sm_pkg::*;
#(
    parameter int unsigned S        = 10,
    parameter int unsigned R        = 10,
    parameter int unsigned Ks       = 10,
    parameter int unsigned Kr       = 10,
    parameter int unsigned MAX_ITER = S * Ks
);
    localparam int unsigned LogS  = sm_log2(S);
    localparam int unsigned LogR  = sm_log2(R);
    localparam int unsigned IterW = sm_cnt_w(MAX_ITER);

    logic                     start;
    logic [S*Ks*LogR-1:0]     s_pref;
    logic [R*Kr*LogS-1:0]     r_pref;
    logic                     busy;
    logic                     done;
    logic                     timeout;
    logic [R*LogS-1:0]        match_list;
    logic [R-1:0]             r_matched;
    logic [IterW-1:0]         iter_count;

    modport master (
        output start, s_pref, r_pref,
        input  busy, done, timeout, match_list, r_matched, iter_count
    );

    modport slave (
        input  start, s_pref, r_pref,
        output busy, done, timeout, match_list, r_matched, iter_count
    );

endinterface

// File: rtl/sm_rank_lookup.sv
// Finds where a candidate proposer sits in one receiver's preference row.
module sm_rank_lookup
    import sm_pkg::*;
#(
    parameter int unsigned S  = 10,
    parameter int unsigned Kr = 10
) (
    input  logic [Kr*sm_log2(S)-1:0] row_i,
    input  logic [sm_log2(S)-1:0]    cand_i,
    output logic                     found_o,
    output logic [sm_log2(Kr)-1:0]   rank_o
);
    localparam int unsigned LogS  = sm_log2(S);
    localparam int unsigned LogKr = sm_log2(Kr);

    // Scan from the back so the most preferred (lowest) matching slot wins.
    always_comb begin
        found_o = 1'b0;
        rank_o  = '0;
        for (int j = int'(Kr) - 1; j >= 0; j--) begin
            if (32'(row_i[LogS*j +: LogS]) < S && row_i[LogS*j +: LogS] == cand_i) begin
                found_o = 1'b1;
                rank_o  = LogKr'(j);
            end
        end
    end

endmodule

// File: rtl/stable_matching_seq.sv
// Gale-Shapley engine evaluating one proposal per clock from latched preference lists.
module stable_matching_seq
    import sm_pkg::*;
#(
    parameter int unsigned S        = 10,
    parameter int unsigned R        = 10,
    parameter int unsigned Ks       = 10,
    parameter int unsigned Kr       = 10,
    parameter int unsigned MAX_ITER = S * Ks
) (
    input logic                 clk,
    input logic                 rst,
    stable_matching_seq_if.slave bus
);
    localparam int unsigned LogS  = sm_log2(S);
    localparam int unsigned LogR  = sm_log2(R);
    localparam int unsigned LogKr = sm_log2(Kr);
    localparam int unsigned PcW   = sm_cnt_w(Ks);
    localparam int unsigned IterW = sm_cnt_w(MAX_ITER);

    sm_state_e              state_q, state_d;
    logic                   busy_q, busy_d, done_q, done_d, timeout_q, timeout_d;
    logic [S*Ks*LogR-1:0]   s_pref_q, s_pref_d;
    logic [R*Kr*LogS-1:0]   r_pref_q, r_pref_d;
    logic [S-1:0][PcW-1:0]  pc_q, pc_d;
    logic [S-1:0]           s_matched_q, s_matched_d;
    logic [R-1:0]           r_matched_q, r_matched_d;
    logic [R-1:0][LogS-1:0] match_q, match_d;
    logic [IterW-1:0]       iter_q, iter_d;

    logic                   any_elig, target_ok, r_taken, accept;
    logic [LogS-1:0]        prop, incumbent;
    logic [LogR-1:0]        target, r_sel;
    logic [Kr*LogS-1:0]     r_row;
    logic                   new_found, inc_found;
    logic [LogKr-1:0]       new_rank, inc_rank;
    int unsigned            entry;

    always_comb begin
        any_elig = 1'b0;
        prop     = '0;
        for (int s = int'(S) - 1; s >= 0; s--) begin
            if (pc_q[s] != '0 && !s_matched_q[s]) begin
                any_elig = 1'b1;
                prop     = LogS'(s);
            end
        end
        // pc counts remaining entries, so Ks - pc is the next list position.
        entry     = (pc_q[prop] == '0) ? 0 : Ks - 32'(pc_q[prop]);
        target    = s_pref_q[LogR*(Ks*32'(prop) + entry) +: LogR];
        target_ok = 32'(target) < R;
        r_sel     = target_ok ? target : '0;
        r_row     = r_pref_q[LogS*Kr*32'(r_sel) +: LogS*Kr];
        incumbent = match_q[r_sel];
        r_taken   = r_matched_q[r_sel];
    end

    sm_rank_lookup #(.S(S), .Kr(Kr)) u_rank_new (
        .row_i   (r_row),
        .cand_i  (prop),
        .found_o (new_found),
        .rank_o  (new_rank)
    );

    sm_rank_lookup #(.S(S), .Kr(Kr)) u_rank_inc (
        .row_i   (r_row),
        .cand_i  (incumbent),
        .found_o (inc_found),
        .rank_o  (inc_rank)
    );

    assign accept = target_ok && new_found && (!r_taken || !inc_found || new_rank < inc_rank);

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = done_q;
        timeout_d   = timeout_q;
        s_pref_d    = s_pref_q;
        r_pref_d    = r_pref_q;
        pc_d        = pc_q;
        s_matched_d = s_matched_q;
        r_matched_d = r_matched_q;
        match_d     = match_q;
        iter_d      = iter_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    state_d     = StRun;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    timeout_d   = 1'b0;
                    s_pref_d    = bus.s_pref;
                    r_pref_d    = bus.r_pref;
                    pc_d        = {S{PcW'(Ks)}};
                    s_matched_d = '0;
                    r_matched_d = '0;
                    match_d     = '0;
                    iter_d      = '0;
                end
            end
            StRun: begin
                if (!any_elig || iter_q == IterW'(MAX_ITER)) begin
                    state_d   = StDone;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    timeout_d = any_elig;
                end else begin
                    pc_d[prop] = pc_q[prop] - PcW'(1);
                    iter_d     = iter_q + IterW'(1);
                    if (accept) begin
                        // A displaced incumbent keeps its pc and resumes from its next entry.
                        if (r_taken) s_matched_d[incumbent] = 1'b0;
                        match_d[r_sel]     = prop;
                        r_matched_d[r_sel] = 1'b1;
                        s_matched_d[prop]  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            s_pref_q    <= '0;
            r_pref_q    <= '0;
            pc_q        <= '0;
            s_matched_q <= '0;
            r_matched_q <= '0;
            match_q     <= '0;
            iter_q      <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            s_pref_q    <= s_pref_d;
            r_pref_q    <= r_pref_d;
            pc_q        <= pc_d;
            s_matched_q <= s_matched_d;
            r_matched_q <= r_matched_d;
            match_q     <= match_d;
            iter_q      <= iter_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.timeout    = timeout_q;
    assign bus.match_list = match_q;
    assign bus.r_matched  = r_matched_q;
    assign bus.iter_count = iter_q;

endmodule

// File: tb/tb_stable_matching_seq.sv
// Directed small-list runs with literal expectations plus random 4x4 runs against a model.
module tb_stable_matching_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stable_matching_seq_if #(.S(2), .R(2), .Ks(2), .Kr(2), .MAX_ITER(4))  ifa ();
    stable_matching_seq_if #(.S(2), .R(2), .Ks(2), .Kr(2), .MAX_ITER(2))  ifb ();
    stable_matching_seq_if #(.S(2), .R(2), .Ks(2), .Kr(1), .MAX_ITER(4))  ifc ();
    stable_matching_seq_if #(.S(4), .R(4), .Ks(4), .Kr(4), .MAX_ITER(16)) ifd ();

    stable_matching_seq #(.S(2), .R(2), .Ks(2), .Kr(2), .MAX_ITER(4))
        u_a (.clk(clk), .rst(rst), .bus(ifa));
    stable_matching_seq #(.S(2), .R(2), .Ks(2), .Kr(2), .MAX_ITER(2))
        u_b (.clk(clk), .rst(rst), .bus(ifb));
    stable_matching_seq #(.S(2), .R(2), .Ks(2), .Kr(1), .MAX_ITER(4))
        u_c (.clk(clk), .rst(rst), .bus(ifc));
    stable_matching_seq #(.S(4), .R(4), .Ks(4), .Kr(4), .MAX_ITER(16))
        u_d (.clk(clk), .rst(rst), .bus(ifd));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model state for the 4x4 instance.
    int         sp [4][4];
    int         rp [4][4];
    logic [7:0] tr_ml [17];
    logic [3:0] tr_rm [17];
    int         np;

    logic       chk_en = 1'b0;
    logic [7:0] exp_ml = '0;
    logic [3:0] exp_rm = '0;
    logic [4:0] exp_iter = '0;
    logic       exp_busy = 1'b0, exp_done = 1'b0, exp_to = 1'b0;

    function automatic int rrank(input int r, input int x);
        for (int j = 0; j < 4; j++) if (rp[r][j] == x) return j;
        return -1;
    endfunction

    function automatic int srank(input int s, input int r);
        for (int j = 0; j < 4; j++) if (sp[s][j] == r) return j;
        return -1;
    endfunction

    // Proposal-by-proposal snapshot of the matching, lowest eligible proposer first.
    task automatic model_run();
        int  pc [4];
        bit  sm [4];
        int  ml [4];
        bit  rmb [4];
        int  s, r;
        for (int i = 0; i < 4; i++) begin
            pc[i] = 4; sm[i] = 0; ml[i] = 0; rmb[i] = 0;
        end
        np = 0;
        tr_ml[0] = '0;
        tr_rm[0] = '0;
        forever begin
            s = -1;
            for (int i = 3; i >= 0; i--) if (pc[i] > 0 && !sm[i]) s = i;
            if (s < 0 || np == 16) break;
            r = sp[s][4 - pc[s]];
            pc[s]--;
            np++;
            if (rrank(r, s) >= 0) begin
                if (!rmb[r]) begin
                    ml[r] = s; rmb[r] = 1; sm[s] = 1;
                end else if (rrank(r, s) < rrank(r, ml[r])) begin
                    sm[ml[r]] = 0; ml[r] = s; sm[s] = 1;
                end
            end
            for (int i = 0; i < 4; i++) begin
                tr_ml[np][2*i +: 2] = 2'(ml[i]);
                tr_rm[np][i]        = rmb[i];
            end
        end
    endtask

    function automatic int blocking_pairs(input logic [7:0] ml, input logic [3:0] rm);
        int ps [4];
        int cnt;
        bit s_better, r_better;
        cnt = 0;
        for (int s = 0; s < 4; s++) ps[s] = -1;
        for (int r = 0; r < 4; r++) if (rm[r]) ps[int'(ml[2*r +: 2])] = r;
        for (int s = 0; s < 4; s++) begin
            for (int r = 0; r < 4; r++) begin
                if (srank(s, r) >= 0 && rrank(r, s) >= 0) begin
                    s_better = (ps[s] < 0) || (srank(s, r) < srank(s, ps[s]));
                    r_better = !rm[r] || (rrank(r, s) < rrank(r, int'(ml[2*r +: 2])));
                    if (s_better && r_better) cnt++;
                end
            end
        end
        return cnt;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("d_match_list", 64'(ifd.match_list), 64'(exp_ml));
            chk("d_r_matched", 64'(ifd.r_matched), 64'(exp_rm));
            chk("d_iter_count", 64'(ifd.iter_count), 64'(exp_iter));
            chk("d_busy", 64'(ifd.busy), 64'(exp_busy));
            chk("d_done", 64'(ifd.done), 64'(exp_done));
            chk("d_timeout", 64'(ifd.timeout), 64'(exp_to));
        end
    end

    // Starts a, b and c together and records the edge after which each raises done.
    task automatic run_small(input bit extra_start);
        int da, db, dc;
        da = 0; db = 0; dc = 0;
        ifa.start = 1'b1; ifb.start = 1'b1; ifc.start = 1'b1;
        @(posedge clk); #1;
        ifa.start = 1'b0; ifb.start = 1'b0; ifc.start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (extra_start && k == 2) ifa.start = 1'b1;
            @(posedge clk); #1;
            ifa.start = 1'b0;
            if (k == 1) begin
                chk("a_busy_k1", 64'(ifa.busy), 64'd1);
                chk("a_iter_k1", 64'(ifa.iter_count), 64'd1);
                chk("a_rm_k1", 64'(ifa.r_matched), 64'b01);
                chk("a_ml_k1", 64'(ifa.match_list), 64'b00);
            end
            if (k == 2) begin
                chk("a_ml_k2", 64'(ifa.match_list), 64'b01);
                chk("a_iter_k2", 64'(ifa.iter_count), 64'd2);
            end
            if (ifa.done && da == 0) da = k;
            if (ifb.done && db == 0) db = k;
            if (ifc.done && dc == 0) dc = k;
        end
        chk("a_done_edge", 64'(da), 64'd4);
        chk("a_match_list", 64'(ifa.match_list), 64'b01);
        chk("a_r_matched", 64'(ifa.r_matched), 64'b11);
        chk("a_iter_count", 64'(ifa.iter_count), 64'd3);
        chk("a_timeout", 64'(ifa.timeout), 64'd0);
        chk("a_busy_end", 64'(ifa.busy), 64'd0);
        chk("b_done_edge", 64'(db), 64'd3);
        chk("b_timeout", 64'(ifb.timeout), 64'd1);
        chk("b_iter_count", 64'(ifb.iter_count), 64'd2);
        chk("b_match_list", 64'(ifb.match_list), 64'b01);
        chk("b_r_matched", 64'(ifb.r_matched), 64'b01);
        chk("c_done_edge", 64'(dc), 64'd4);
        chk("c_r_matched", 64'(ifc.r_matched), 64'b10);
        chk("c_match_list", 64'(ifc.match_list), 64'b10);
        chk("c_iter_count", 64'(ifc.iter_count), 64'd3);
        chk("c_timeout", 64'(ifc.timeout), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        ifa.start = 1'b0; ifb.start = 1'b0; ifc.start = 1'b0; ifd.start = 1'b0;
        // s0:[0,1] s1:[0,1]; r0:[1,0] r1:[0,1]
        ifa.s_pref = 4'b1010; ifa.r_pref = 4'b1001;
        ifb.s_pref = 4'b1010; ifb.r_pref = 4'b1001;
        // s0:[0,1] s1:[1,0]; r0:[1] r1:[1]
        ifc.s_pref = 4'b0110; ifc.r_pref = 2'b11;
        ifd.s_pref = '0;      ifd.r_pref = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(ifa.busy), 64'd0);
        chk("rst_done", 64'(ifa.done), 64'd0);
        chk("rst_timeout", 64'(ifa.timeout), 64'd0);
        chk("rst_match_list", 64'(ifa.match_list), 64'd0);
        chk("rst_r_matched", 64'(ifa.r_matched), 64'd0);
        chk("rst_iter_count", 64'(ifa.iter_count), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_small(1'b0);
        run_small(1'b1);

        // Reset in the middle of a run clears outputs without waiting for a clock.
        ifa.start = 1'b1;
        @(posedge clk); #1;
        ifa.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_busy", 64'(ifa.busy), 64'd0);
        chk("midrst_done", 64'(ifa.done), 64'd0);
        chk("midrst_timeout", 64'(ifa.timeout), 64'd0);
        chk("midrst_match_list", 64'(ifa.match_list), 64'd0);
        chk("midrst_r_matched", 64'(ifa.r_matched), 64'd0);
        chk("midrst_iter_count", 64'(ifa.iter_count), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_small(1'b0);

        chk_en = 1'b1;
        for (int run = 0; run < 1000; run++) begin
            for (int s = 0; s < 4; s++) begin
                for (int j = 0; j < 4; j++) begin
                    sp[s][j] = int'($urandom_range(0, 3));
                    rp[s][j] = int'($urandom_range(0, 3));
                    ifd.s_pref[2*(4*s+j) +: 2] = 2'(sp[s][j]);
                    ifd.r_pref[2*(4*s+j) +: 2] = 2'(rp[s][j]);
                end
            end
            model_run();
            ifd.start = 1'b1;
            @(posedge clk); #1;
            ifd.start = 1'b0;
            exp_ml = '0; exp_rm = '0; exp_iter = '0;
            exp_busy = 1'b1; exp_done = 1'b0; exp_to = 1'b0;
            for (int k = 1; k <= np + 2; k++) begin
                @(posedge clk); #1;
                exp_ml   = tr_ml[(k < np) ? k : np];
                exp_rm   = tr_rm[(k < np) ? k : np];
                exp_iter = 5'((k < np) ? k : np);
                exp_busy = (k <= np);
                exp_done = (k > np);
            end
            chk("d_blocking_pairs", 64'(blocking_pairs(ifd.match_list, ifd.r_matched)), 64'd0);
            chk("d_iter_le_16", 64'(ifd.iter_count <= 5'd16), 64'd1);
        end
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
